mux_logic_unit_pipe: RTL and testbench
======================================

Name: mux_logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the single-bit mux-built OR gate.
- Computes a W-bit bitwise AND/OR/XOR/NAND of two operands; every logic function is built only from 2:1 mux instances, with no `&`, `|`, `^` or `~` operators in the datapath.
- Adds a valid/ready handshake, a single-entry output register, a chain mode that feeds the last result back as operand A, and a wrapping transaction counter.
- Sits between a stimulus/producer stage and a consumer stage in the combinational-logic exercise framework.

Parameters:
- W, 8, operand and result width in bits (W >= 1).
- CNT_W, 16, width of the completed-transaction counter (CNT_W >= 1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- up_valid  input  1  an upstream operation is presented.
- up_ready  output  1  the block can accept an operation this cycle.
- a  input  W  operand A; ignored when chain=1.
- b  input  W  operand B.
- op  input  2  operation code, gate_pkg::op_t: 0 AND, 1 OR, 2 XOR, 3 NAND.
- chain  input  1  when 1, operand A is taken from the last accepted result register.
- down_valid  output  1  res holds a valid result.
- down_ready  input  1  downstream accepts res this cycle.
- res  output  W  registered result.
- done_cnt  output  CNT_W  number of results accepted downstream; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at a rising edge): down_valid=0, res=0, done_cnt=0, last result register (last_res)=0. up_ready is combinational and reads 1 after reset.
- up_ready = (!down_valid) || down_ready. This is a pipeline register with no skid buffer; a bubble-free stream is possible when down_ready is held high.
- Accept: up_valid && up_ready at the edge. Then res <= f(op, A, b), down_valid <= 1, last_res <= f(op, A, b).
  - A = chain ? last_res : a.
  - Latency is exactly 1 cycle from accept to down_valid.
- Drain: down_valid && down_ready && !accept gives down_valid <= 0; res holds its value (not cleared).
- Simultaneous drain and accept in the same cycle: res and down_valid=1 are replaced by the new result. No gap and no loss.
- Stall: down_valid=1 and down_ready=0:
  - up_ready=0;
  - res and down_valid are held stable;
  - up_valid is ignored, with no state change.
- done_cnt increments by 1 on every cycle with down_valid && down_ready, and wraps from 2^CNT_W-1 to 0.
- last_res updates only on accept. A drained or stalled cycle does not change it.
- Chain directly after reset uses last_res=0.
- Mux construction, per bit i, with x=A[i] and y=b[i]; t1 and t0 are constant wires:
  - AND = mux(d0=0, d1=y, sel=x)
  - OR = mux(d0=y, d1=1, sel=x)
  - NOTy = mux(d0=1, d1=0, sel=y)
  - XOR = mux(d0=y, d1=NOTy, sel=x)
  - NAND = mux(d0=1, d1=NOTy, sel=x)
  - Op selection is a 4:1 mux tree of 2:1 muxes, with sel = op[0] at the first level and op[1] at the second.
- rst asserted mid-operation (including during a stall) discards the pending result and clears all state at that edge. rst has priority over accept and drain.
- op values are sampled only at accept. X or undefined op is not specified.

Decomposition:
- Package gate_pkg:
  - typedef enum logic [1:0] op_t {OP_AND=0, OP_OR=1, OP_XOR=2, OP_NAND=3};
  - no other shared constants.
- Sub-module mux (1-bit 2:1; ports d0, d1, sel, y; y = sel ? d1 : d0). All datapath logic instantiates it through generate loops over W.
- Handshake, registers and counter stay in mux_logic_unit_pipe.

Test Plan:
- Reset then exhaustive ops, W=8, down_ready=1: a=8'hF0, b=8'hCC for op 0..3 -> res one cycle later = C0, FC, 3C, 3F; down_valid high each cycle; done_cnt=4.
- Backpressure: accept AND(FF,0F), hold down_ready=0 for 3 cycles with up_valid=1 and a different a/b -> up_ready=0; res stays 0F and down_valid stays 1; when down_ready=1 the next item is accepted in the same cycle.
- Chain: accept XOR(a=AA, b=FF) -> res 55; then chain=1, OR b=0F with a=00 driven -> res 5F; then chain=1, NAND b=F0 -> res AF.
- Chain directly after reset: chain=1, OR b=12 -> res 12 (last_res=0).
- Counter wrap with CNT_W=2: 5 back-to-back drained results -> done_cnt sequence 1, 2, 3, 0, 1.
- Reset mid-stall: down_valid=1, down_ready=0, assert rst one cycle -> next cycle down_valid=0, res=0, done_cnt=0, up_ready=1; a subsequent chain operation uses last_res=0.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared types for the mux-built logic unit.
package gate_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } op_t;

endpackage

// File: rtl/mux.sv
// 1-bit 2:1 multiplexer; the only primitive the logic datapath is built from.
module mux (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_logic_unit_pipe.sv
// Pipelined W-bit AND/OR/XOR/NAND unit built purely from 2:1 muxes, with a
// single-entry valid/ready output register, result chaining and a
// completed-transaction counter.
module mux_logic_unit_pipe
    import gate_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [1:0]       op,
    input  logic             chain,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [W-1:0]     res,
    output logic [CNT_W-1:0] done_cnt
);

    logic [W-1:0] last_res;
    logic [W-1:0] opa;
    logic [W-1:0] and_v;
    logic [W-1:0] or_v;
    logic [W-1:0] noty_v;
    logic [W-1:0] xor_v;
    logic [W-1:0] nand_v;
    logic [W-1:0] lvl_lo;
    logic [W-1:0] lvl_hi;
    logic [W-1:0] f_v;
    logic         t1;
    logic         t0;
    logic         accept;
    logic         drain;
    op_t          op_sel;

    assign t1     = 1'b1;
    assign t0     = 1'b0;
    assign op_sel = op_t'(op);

    // Per-bit datapath: operand select, the four gate functions, 4:1 op tree.
    for (genvar i = 0; i < W; i++) begin : g_bit
        mux u_asel (.d0(a[i]),      .d1(last_res[i]), .sel(chain),     .y(opa[i]));
        mux u_and  (.d0(t0),        .d1(b[i]),        .sel(opa[i]),    .y(and_v[i]));
        mux u_or   (.d0(b[i]),      .d1(t1),          .sel(opa[i]),    .y(or_v[i]));
        mux u_noty (.d0(t1),        .d1(t0),          .sel(b[i]),      .y(noty_v[i]));
        mux u_xor  (.d0(b[i]),      .d1(noty_v[i]),   .sel(opa[i]),    .y(xor_v[i]));
        mux u_nand (.d0(t1),        .d1(noty_v[i]),   .sel(opa[i]),    .y(nand_v[i]));
        mux u_lo   (.d0(and_v[i]),  .d1(or_v[i]),     .sel(op_sel[0]), .y(lvl_lo[i]));
        mux u_hi   (.d0(xor_v[i]),  .d1(nand_v[i]),   .sel(op_sel[0]), .y(lvl_hi[i]));
        mux u_top  (.d0(lvl_lo[i]), .d1(lvl_hi[i]),   .sel(op_sel[1]), .y(f_v[i]));
    end

    // No skid buffer: accept only when the output slot is empty or draining.
    always_comb begin
        up_ready = (!down_valid) || down_ready;
        accept   = up_valid && up_ready;
        drain    = down_valid && down_ready;
    end

    // Output register, chain register and counter; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            down_valid <= 1'b0;
            res        <= '0;
            last_res   <= '0;
            done_cnt   <= '0;
        end else begin
            if (accept) begin
                res        <= f_v;
                last_res   <= f_v;
                down_valid <= 1'b1;
            end else if (drain) begin
                down_valid <= 1'b0;
            end
            if (drain) begin
                done_cnt <= done_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_logic_unit_pipe.sv
// Directed bench with a reference model and result scoreboard; a second
// instance with a 2-bit counter shares the stimulus to exercise wrap-around.
module tb_mux_logic_unit_pipe;
    import gate_pkg::*;

    logic        clk;
    logic        rst;
    logic        up_valid;
    logic        up_ready;
    logic        up_ready2;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  op;
    logic        chain;
    logic        down_valid;
    logic        down_valid2;
    logic        down_ready;
    logic [7:0]  res;
    logic [7:0]  res2;
    logic [15:0] done_cnt;
    logic [1:0]  done_cnt2;

    int checks = 0;
    int fails  = 0;

    logic [7:0]  sb[$];
    logic        m_dv;
    logic [7:0]  m_res;
    logic [7:0]  m_last;
    logic [15:0] m_cnt;

    mux_logic_unit_pipe #(.W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready),
        .a(a), .b(b), .op(op), .chain(chain), .down_valid(down_valid),
        .down_ready(down_ready), .res(res), .done_cnt(done_cnt)
    );

    mux_logic_unit_pipe #(.W(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready2),
        .a(a), .b(b), .op(op), .chain(chain), .down_valid(down_valid2),
        .down_ready(down_ready), .res(res2), .done_cnt(done_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_f(input logic [1:0] o, input logic [7:0] x,
                                         input logic [7:0] y);
        case (o)
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: model the edge from current inputs, then compare after it.
    task automatic tick();
        logic       m_ur;
        logic       acc;
        logic       drn;
        logic [7:0] opa;
        logic [7:0] r;
        #1;
        m_ur = !m_dv || down_ready;
        chk("up_ready", {15'd0, up_ready}, {15'd0, m_ur});
        chk("up_ready2", {15'd0, up_ready2}, {15'd0, m_ur});
        if (rst) begin
            m_dv = 1'b0; m_res = '0; m_last = '0; m_cnt = '0;
            sb.delete();
        end else begin
            acc = up_valid && m_ur;
            drn = m_dv && down_ready;
            if (drn) begin
                void'(sb.pop_front());
                m_cnt++;
            end
            if (acc) begin
                opa    = chain ? m_last : a;
                r      = ref_f(op, opa, b);
                sb.push_back(r);
                m_last = r;
                m_res  = r;
            end
            m_dv = acc ? 1'b1 : (drn ? 1'b0 : m_dv);
        end
        @(posedge clk);
        #1;
        chk("down_valid", {15'd0, down_valid}, {15'd0, m_dv});
        chk("down_valid2", {15'd0, down_valid2}, {15'd0, m_dv});
        chk("res_held", {8'd0, res}, {8'd0, m_res});
        chk("res2", {8'd0, res2}, {8'd0, m_res});
        if (m_dv) begin
            if (sb.size() == 0) chk("sb_underflow", 16'd0, 16'd1);
            else chk("res_sb", {8'd0, res}, {8'd0, sb[0]});
        end
        chk("done_cnt", done_cnt, m_cnt);
        chk("done_cnt2", {14'd0, done_cnt2}, {14'd0, m_cnt[1:0]});
    endtask

    task automatic drive(input logic v, input logic [1:0] o, input logic [7:0] xa,
                         input logic [7:0] xb, input logic c);
        up_valid = v; op = o; a = xa; b = xb; chain = c;
    endtask

    task automatic do_reset();
        rst = 1'b1; up_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst_dv", {15'd0, down_valid}, 16'd0);
        chk("rst_res", {8'd0, res}, 16'd0);
        chk("rst_cnt", done_cnt, 16'd0);
        chk("rst_ur", {15'd0, up_ready}, 16'd1);
    endtask

    initial begin
        logic [7:0] exp_ops[4];
        logic [1:0] exp_wrap[5];
        exp_ops  = '{8'hC0, 8'hFC, 8'h3C, 8'h3F};
        exp_wrap = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        m_dv = 1'b0; m_res = '0; m_last = '0; m_cnt = '0;
        rst = 1'b1; up_valid = 1'b0; a = '0; b = '0; op = '0; chain = 1'b0;
        down_ready = 1'b1;
        do_reset();

        // All four ops, streaming with down_ready high.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 8'hF0, 8'hCC, 1'b0);
            tick();
            chk("op_lit", {8'd0, res}, {8'd0, exp_ops[i]});
            chk("op_dv", {15'd0, down_valid}, 16'd1);
        end
        drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b0);
        tick();
        chk("op_cnt4", done_cnt, 16'd4);

        // Backpressure: stall three cycles with a different request pending.
        drive(1'b1, OP_AND, 8'hFF, 8'h0F, 1'b0);
        tick();
        chk("bp_first", {8'd0, res}, 16'h000F);
        down_ready = 1'b0;
        drive(1'b1, OP_OR, 8'h12, 8'h34, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold", {8'd0, res}, 16'h000F);
            chk("bp_ur", {15'd0, up_ready}, 16'd0);
        end
        down_ready = 1'b1;
        tick();
        chk("bp_next", {8'd0, res}, 16'h0036);
        drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b0);
        tick();

        // Chaining the previous result as operand A.
        drive(1'b1, OP_XOR, 8'hAA, 8'hFF, 1'b0);
        tick();
        chk("ch_xor", {8'd0, res}, 16'h0055);
        drive(1'b1, OP_OR, 8'h00, 8'h0F, 1'b1);
        tick();
        chk("ch_or", {8'd0, res}, 16'h005F);
        drive(1'b1, OP_NAND, 8'h00, 8'hF0, 1'b1);
        tick();
        chk("ch_nand", {8'd0, res}, 16'h00AF);
        drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        chk("drain_hold", {8'd0, res}, 16'h00AF);

        // Chain straight after reset uses zero.
        do_reset();
        drive(1'b1, OP_OR, 8'hEE, 8'h12, 1'b1);
        tick();
        chk("ch_rst", {8'd0, res}, 16'h0012);

        // Counter wrap on the 2-bit instance.
        do_reset();
        drive(1'b1, OP_XOR, 8'h5A, 8'h3C, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b0);
            else drive(1'b1, 2'(i), 8'(8'h11 * i), 8'hA5, 1'b0);
            tick();
            chk("wrap", {14'd0, done_cnt2}, {14'd0, exp_wrap[i]});
        end

        // Reset in the middle of a stall.
        drive(1'b1, OP_AND, 8'hF3, 8'h7E, 1'b0);
        tick();
        down_ready = 1'b0;
        drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b0);
        tick();
        chk("stall_dv", {15'd0, down_valid}, 16'd1);
        do_reset();
        down_ready = 1'b1;
        drive(1'b1, OP_XOR, 8'hFF, 8'h5A, 1'b1);
        tick();
        chk("rst_chain", {8'd0, res}, 16'h005A);
        drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
